// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions used by the arbiter and the AHB2APB bridge slave
// interface: Htrans encodings, arbiter state type and hold-counter width.
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int HOLD_W = 8;

    typedef enum logic {
        ARB_PARK  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // BUSY and SEQ are the only encodings that continue an existing burst.
    function automatic logic htrans_in_burst(input logic [1:0] trans);
        return (trans == HTRANS_BUSY) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational cyclic first-one search. Starting at i_last+1 and wrapping,
// returns the index of the first set bit of i_req. i_last itself is checked
// last, so a lone requester that is also the last owner is still found.
//
// Ports:
//   i_req   [NUM_M-1:0]  request vector
//   i_last  [MW-1:0]     index the search starts after
//   o_idx   [MW-1:0]     selected index (0 when o_vld is low)
//   o_vld                at least one request present
// ---------------------------------------------------------------------------
module rr_picker
    import ahb_pkg::*;
#(
    parameter  int NUM_M = 4,
    localparam int MW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [MW-1:0]    i_last,
    output logic [MW-1:0]    o_idx,
    output logic             o_vld
);

    // Walk the offsets from farthest to nearest so the nearest hit is the
    // one that survives; no early exit needed.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NUM_M]) begin
                o_idx = MW'((int'(i_last) + k) % NUM_M);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Round-robin arbiter sharing the AHB2APB bridge slave port between up to
// four AHB masters. Grants address-phase ownership, never splits a burst,
// bounds ownership with a hold timer, and routes write data from the master
// that owns the data phase.
//
// Ports:
//   Hclk, Hresetn         clock, asynchronous active-low reset
//   Hbusreq   [NUM_M]     per-master bus request
//   Htrans_m  [2*NUM_M]   per-master Htrans (master i at [2i+1:2i])
//   Haddr_m   [32*NUM_M]  per-master address
//   Hwrite_m  [NUM_M]     per-master write flag
//   Hwdata_m  [32*NUM_M]  per-master write data
//   Hreadyout             ready from the bridge
//   Hgrant    [NUM_M]     registered one-hot grant
//   Hmaster   [MW]        registered address-phase owner
//   Htrans/Haddr/Hwrite   address/control of Hmaster
//   Hwdata                write data of the data-phase owner
//   Hreadyin              Hreadyout looped back to masters and bridge
// ---------------------------------------------------------------------------
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_M    = 4,
    parameter  int PARK_M   = 0,
    parameter  int MAX_HOLD = 16,
    localparam int MW       = $clog2(NUM_M)
) (
    input  logic                Hclk,
    input  logic                Hresetn,
    input  logic [NUM_M-1:0]    Hbusreq,
    input  logic [2*NUM_M-1:0]  Htrans_m,
    input  logic [32*NUM_M-1:0] Haddr_m,
    input  logic [NUM_M-1:0]    Hwrite_m,
    input  logic [32*NUM_M-1:0] Hwdata_m,
    input  logic                Hreadyout,
    output logic [NUM_M-1:0]    Hgrant,
    output logic [MW-1:0]       Hmaster,
    output logic [1:0]          Htrans,
    output logic [31:0]         Haddr,
    output logic                Hwrite,
    output logic [31:0]         Hwdata,
    output logic                Hreadyin
);

    localparam logic [MW-1:0]     LP_PARK     = MW'(PARK_M);
    localparam logic [HOLD_W-1:0] LP_MAX_HOLD = HOLD_W'(MAX_HOLD);

    arb_state_t        r_state,  w_state_nxt;
    logic [MW-1:0]     r_master, w_master_nxt;
    logic [MW-1:0]     r_last,   w_last_nxt;
    logic [MW-1:0]     r_dmaster;
    logic [NUM_M-1:0]  r_grant,  w_grant_nxt;
    logic [HOLD_W-1:0] r_hold,   w_hold_nxt;

    logic [1:0]        w_owner_trans;
    logic              w_owner_req;
    logic [NUM_M-1:0]  w_owner_oh;
    logic              w_others_req;
    logic              w_hold_expired;
    logic              w_arb_point;
    logic [MW-1:0]     w_pick_last;
    logic [MW-1:0]     w_pick_idx;
    logic              w_pick_vld;

    // ---------------- owner status ----------------
    assign w_owner_trans  = Htrans_m[2*int'(r_master) +: 2];
    assign w_owner_req    = Hbusreq[r_master];
    assign w_owner_oh     = NUM_M'(1) << r_master;
    assign w_others_req   = |(Hbusreq & ~w_owner_oh);
    assign w_hold_expired = (r_hold >= LP_MAX_HOLD);

    // Only a non-burst beat with the bus ready may change ownership.
    assign w_arb_point = Hreadyout && !htrans_in_burst(w_owner_trans) &&
                         (!w_owner_req || (w_hold_expired && w_others_req));

    // While parked, r_master sits on PARK_M, so the rotation resumes from
    // the last real owner held in r_last.
    assign w_pick_last = (r_state == ARB_PARK) ? r_last : r_master;

    rr_picker #(
        .NUM_M (NUM_M)
    ) u_picker (
        .i_req  (Hbusreq),
        .i_last (w_pick_last),
        .o_idx  (w_pick_idx),
        .o_vld  (w_pick_vld)
    );

    // ---------------- next-state ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_master_nxt = r_master;
        w_last_nxt   = r_last;
        w_hold_nxt   = r_hold;

        if (Hreadyout) begin
            unique case (r_state)
                ARB_PARK: begin
                    if (w_pick_vld) begin
                        w_state_nxt  = ARB_OWNED;
                        w_master_nxt = w_pick_idx;
                        w_last_nxt   = w_pick_idx;
                    end
                    w_hold_nxt = '0;
                end
                ARB_OWNED: begin
                    if (w_arb_point) begin
                        if (w_pick_vld) begin
                            // Picking the current owner means it is the only
                            // requester: it keeps the bus with a fresh count.
                            w_master_nxt = w_pick_idx;
                            w_last_nxt   = w_pick_idx;
                        end else begin
                            w_state_nxt  = ARB_PARK;
                            w_master_nxt = LP_PARK;
                        end
                        w_hold_nxt = '0;
                    end else if (!w_hold_expired) begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = ARB_PARK;
                    w_master_nxt = LP_PARK;
                    w_hold_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_grant_nxt = '0;
        for (int i = 0; i < NUM_M; i++) begin
            w_grant_nxt[i] = (w_master_nxt == MW'(i));
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state   <= ARB_PARK;
            r_master  <= LP_PARK;
            r_last    <= LP_PARK;
            r_dmaster <= LP_PARK;
            r_grant   <= NUM_M'(1) << LP_PARK;
            r_hold    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_master <= w_master_nxt;
            r_last   <= w_last_nxt;
            r_grant  <= w_grant_nxt;
            r_hold   <= w_hold_nxt;
            // The address-phase owner of this beat owns the next data phase.
            if (Hreadyout) begin
                r_dmaster <= r_master;
            end
        end
    end

    // ---------------- bridge-side muxes ----------------
    assign Hgrant   = r_grant;
    assign Hmaster  = r_master;
    assign Htrans   = w_owner_trans;
    assign Haddr    = Haddr_m[32*int'(r_master) +: 32];
    assign Hwrite   = Hwrite_m[r_master];
    assign Hwdata   = Hwdata_m[32*int'(r_dmaster) +: 32];
    assign Hreadyin = Hreadyout;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

    localparam int NM   = 4;
    localparam int PARK = 0;
    localparam int MAXH = 4;

    logic           Hclk;
    logic           Hresetn;
    logic [NM-1:0]  busreq;
    logic [NM-1:0]  hwrite_v;
    logic [1:0]     trans [NM];
    logic [31:0]    addr  [NM];
    logic [31:0]    wdata [NM];
    logic           hreadyout;

    logic [2*NM-1:0]  Htrans_m;
    logic [32*NM-1:0] Haddr_m;
    logic [32*NM-1:0] Hwdata_m;

    logic [NM-1:0]  Hgrant;
    logic [1:0]     Hmaster;
    logic [1:0]     Htrans;
    logic [31:0]    Haddr;
    logic           Hwrite;
    logic [31:0]    Hwdata;
    logic           Hreadyin;

    always_comb begin
        Htrans_m = '0;
        Haddr_m  = '0;
        Hwdata_m = '0;
        for (int i = 0; i < NM; i++) begin
            Htrans_m[2*i +: 2]  = trans[i];
            Haddr_m[32*i +: 32] = addr[i];
            Hwdata_m[32*i +: 32] = wdata[i];
        end
    end

    ahb_arbiter #(
        .NUM_M    (NM),
        .PARK_M   (PARK),
        .MAX_HOLD (MAXH)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (busreq),
        .Htrans_m  (Htrans_m),
        .Haddr_m   (Haddr_m),
        .Hwrite_m  (hwrite_v),
        .Hwdata_m  (Hwdata_m),
        .Hreadyout (hreadyout),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hwdata    (Hwdata),
        .Hreadyin  (Hreadyin)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: who owns the address phase, who owns the data phase,
    // whether the bus is parked, how long the owner has held it.
    int m_owner, m_down, m_last, m_hold;
    bit m_parked;

    function automatic int rr_next(input logic [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = PARK;
        m_down   = PARK;
        m_last   = PARK;
        m_hold   = 0;
        m_parked = 1'b1;
    endtask

    task automatic model_step();
        int  prev;
        int  nxt;
        bit  burst;
        bit  others;
        if (!hreadyout) return;
        prev = m_owner;
        nxt  = rr_next(busreq, m_last);
        if (m_parked) begin
            if (nxt >= 0) begin
                m_owner  = nxt;
                m_last   = nxt;
                m_parked = 1'b0;
            end
            m_hold = 0;
        end else begin
            burst  = (trans[m_owner] == 2'b01) || (trans[m_owner] == 2'b11);
            others = 1'b0;
            for (int j = 0; j < NM; j++)
                if (j != m_owner && busreq[j]) others = 1'b1;
            if (!burst && (!busreq[m_owner] || (m_hold >= MAXH && others))) begin
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_last  = nxt;
                end else begin
                    m_owner  = PARK;
                    m_parked = 1'b1;
                end
                m_hold = 0;
            end else begin
                m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
            end
        end
        m_down = prev;
    endtask

    task automatic check_outputs();
        logic [NM-1:0] g;
        g = '0;
        g[m_owner] = 1'b1;
        chk("grant",    64'(Hgrant),   64'(g));
        chk("hmaster",  64'(Hmaster),  64'(m_owner));
        chk("haddr",    64'(Haddr),    64'(addr[m_owner]));
        chk("htrans",   64'(Htrans),   64'(trans[m_owner]));
        chk("hwrite",   64'(Hwrite),   64'(hwrite_v[m_owner]));
        chk("hwdata",   64'(Hwdata),   64'(wdata[m_down]));
        chk("hreadyin", 64'(Hreadyin), 64'(hreadyout));
    endtask

    // One clock: check at the falling edge, advance the model, return just
    // after the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        @(negedge Hclk);
        check_outputs();
        model_step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic randomize_inputs();
        busreq   = NM'($urandom);
        hwrite_v = NM'($urandom);
        for (int i = 0; i < NM; i++) begin
            trans[i] = 2'($urandom_range(0, 3));
            addr[i]  = $urandom;
            wdata[i] = $urandom;
        end
        hreadyout = ($urandom_range(0, 4) != 0);
    endtask

    task automatic quiet_inputs();
        busreq    = '0;
        hwrite_v  = '0;
        hreadyout = 1'b1;
        for (int i = 0; i < NM; i++) begin
            trans[i] = 2'b00;
            addr[i]  = 32'h1000_0000 + 32'(i);
            wdata[i] = 32'hD000_0000 + 32'(i);
        end
    endtask

    int exp_rr [5] = '{0, 1, 2, 3, 0};

    initial begin
        int o;
        Hresetn = 1'b1;
        randomize_inputs();
        model_reset();
        #2 Hresetn = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            @(negedge Hclk);
            check_outputs();
            chk("rst_grant",  64'(Hgrant),  64'(4'b0001));
            chk("rst_master", 64'(Hmaster), 64'(0));
            chk("rst_haddr",  64'(Haddr),   64'(addr[0]));
            randomize_inputs();
        end
        @(posedge Hclk);
        #1;
        Hresetn = 1'b1;
        quiet_inputs();
        cycle();

        // Single write by master 2
        busreq      = 4'b0100;
        trans[2]    = 2'b10;
        addr[2]     = 32'h8000_0001;
        hwrite_v[2] = 1'b1;
        cycle();
        chk("sw_grant", 64'(Hgrant), 64'(4'b0100));
        chk("sw_haddr", 64'(Haddr),  64'(32'h8000_0001));
        busreq   = '0;
        trans[2] = 2'b00;
        wdata[2] = 32'h0000_1234;
        cycle();
        chk("sw_hwdata", 64'(Hwdata), 64'(32'h0000_1234));

        // Burst protection: master 1 bursts while master 3 waits
        busreq = 4'b0010;
        cycle();
        chk("bp_grant1", 64'(Hgrant), 64'(4'b0010));
        busreq   = 4'b1010;
        trans[1] = 2'b10;
        addr[1]  = 32'h8000_0001;
        cycle();
        chk("bp_nonseq", 64'(Hgrant), 64'(4'b0010));
        busreq = 4'b1000;
        for (int b = 2; b <= 4; b++) begin
            trans[1] = 2'b11;
            addr[1]  = 32'h8000_0000 + 32'(b);
            cycle();
            chk("bp_seq", 64'(Hgrant), 64'(4'b0010));
        end
        trans[1] = 2'b00;
        cycle();
        chk("bp_handover", 64'(Hgrant), 64'(4'b1000));

        // Park, then round-robin with all four requesting
        busreq = '0;
        cycle();
        chk("park_master", 64'(Hmaster), 64'(PARK));
        busreq = 4'b1111;
        cycle();
        chk("rr_first", 64'(Hmaster), 64'(exp_rr[0]));
        for (int s = 1; s < 5; s++) begin
            o        = m_owner;
            busreq   = 4'b1111;
            trans[o] = 2'b10;
            cycle();
            trans[o]  = 2'b00;
            busreq[o] = 1'b0;
            cycle();
            chk("rr_seq", 64'(Hmaster), 64'(exp_rr[s]));
        end

        // Hold limit: master 0 back-to-back NONSEQ, master 1 waiting
        busreq   = 4'b0011;
        trans[0] = 2'b10;
        for (int c = 1; c <= MAXH; c++) begin
            cycle();
            chk("hold_keep", 64'(Hmaster), 64'(0));
        end
        cycle();
        chk("hold_switch", 64'(Hmaster), 64'(1));

        // Wait states during a handover from 1 to 2
        busreq    = 4'b0100;
        trans[0]  = 2'b00;
        trans[1]  = 2'b00;
        hreadyout = 1'b0;
        repeat (3) begin
            cycle();
            chk("ws_grant",  64'(Hgrant),  64'(4'b0010));
            chk("ws_master", 64'(Hmaster), 64'(1));
            chk("ws_hwdata", 64'(Hwdata),  64'(wdata[0]));
        end
        hreadyout = 1'b1;
        cycle();
        chk("ws_grant2",  64'(Hgrant), 64'(4'b0100));
        chk("ws_hwdata2", 64'(Hwdata), 64'(wdata[1]));

        // Randomized traffic, with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i == 200) begin
                #2 Hresetn = 1'b0;
                #1;
                model_reset();
                check_outputs();
                @(negedge Hclk);
                check_outputs();
                @(posedge Hclk);
                #1 Hresetn = 1'b1;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB arbiter that shares the single AHB2APB bridge slave port between up to four AHB masters. It sits between the masters and the bridge's AHB slave interface. It grants address-phase ownership, multiplexes the granted master's address/control and the data-phase owner's write data onto the bridge, and never breaks an in-progress burst. An ownership timer bounds how long one master holds the bus while others wait.

## Interface
Parameters:
- NUM_M, 4: number of masters, 2..4.
- MW, $clog2(NUM_M): master index width (derived, not overridden).
- PARK_M, 0: master parked on when nobody requests.
- MAX_HOLD, 16: ownership cycles before forced handover at next non-burst boundary; 1..255.

Ports:
- Hclk  in  1  bus clock; all state on rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- Hbusreq  in  NUM_M  per-master bus request.
- Htrans_m  in  2*NUM_M  per-master Htrans, master i at [2i+1:2i].
- Haddr_m  in  32*NUM_M  per-master address.
- Hwrite_m  in  NUM_M  per-master write flag.
- Hwdata_m  in  32*NUM_M  per-master write data.
- Hreadyout  in  1  ready from bridge.
- Hgrant  out  NUM_M  one-hot grant, registered.
- Hmaster  out  MW  address-phase owner, registered.
- Htrans, Haddr, Hwrite  out  2/32/1  muxed from Hmaster (combinational).
- Hwdata  out  32  muxed from data-phase owner (combinational).
- Hreadyin  out  1  equals Hreadyout; fed back to masters and bridge.

## Operation
- States: PARK (no requester owns; Hgrant on PARK_M) and OWNED (granted master requested).
- Owner is "in burst" when its Htrans is BUSY or SEQ.
- Arbitration point: a cycle with Hreadyout=1 where the owner is not in burst, and either Hbusreq[owner]=0 or hold count ≥ MAX_HOLD with another request pending.
- At an arbitration point, the next owner is the first requester scanning cyclically from owner+1. If the current owner is the only requester, it keeps the bus and the hold count resets to 0.
- No requester at an arbitration point → PARK on PARK_M. From PARK, any Hbusreq grants immediately (next edge, Hreadyout=1), using round-robin from the last owner.
- Hold counter: 8-bit. It increments each Hreadyout=1 cycle in OWNED, saturates at MAX_HOLD, and clears on ownership change or PARK entry.
- Data-phase owner register: loads Hmaster on every Hreadyout=1 edge. Hwdata is selected from it, so write data follows its address phase by one cycle even across a handover.
- Hreadyout=0 freezes Hgrant, Hmaster, the data-phase owner, and the hold counter.
- A parked master driving NONSEQ without Hbusreq is passed through. This is legal default-master behaviour.

## Timing
- Reset (async assert, sync-free release): Hgrant = one-hot PARK_M, Hmaster = PARK_M, data-phase owner = PARK_M, hold count = 0, state PARK. The muxed outputs then reflect master PARK_M.
- Grant latency: Hbusreq sampled at edge N with an arbitration point → Hgrant/Hmaster change after edge N. The new owner's address phase is the cycle after edge N, and its first write data is one Hreadyout=1 cycle later.
- Simultaneous requests from all masters with owner 1 releasing → grant 2, then 3, 0, 1 on successive releases.
- Owner in SEQ/BUSY at MAX_HOLD expiry: no handover until its Htrans returns to IDLE/NONSEQ with Hreadyout=1.
- Reset mid-burst: immediate return to reset values. No partial state survives.

## Structure
- Shared package ahb_pkg: HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11. The bridge slave interface uses the same constants.
- One sub-module, rr_picker: combinational cyclic first-one search. Inputs are the request vector and the last-owner index; outputs are the next index and a valid flag.
- Top: FSM, hold counter, owner registers, address/data muxes.

## Test plan
- Reset: Hresetn=0 with random inputs → Hgrant=4'b0001, Hmaster=0; Haddr equals master 0's Haddr.
- Single write: master 2 requests, Htrans=NONSEQ, Haddr=32'h80000001, Hwdata=32'h1234 next cycle → Hgrant=4'b0100 one edge later. The bridge sees Haddr 32'h80000001, then Hwdata 32'h1234.
- Burst protection: master 1 runs a 4-beat SEQ burst (32'h80000001..04) while master 3 requests → no grant change until master 1 returns to IDLE, then Hgrant=4'b1000.
- Round-robin: all four request continuously, each releasing after one transfer → Hmaster sequence 0,1,2,3,0.
- Hold limit: MAX_HOLD=4, master 0 issues back-to-back NONSEQ, master 1 requests → handover to master 1 after the 4th counted cycle.
- Wait states: Hreadyout=0 for 3 cycles during a handover → Hgrant, Hmaster, and Hwdata source frozen; the handover completes on the first Hreadyout=1 edge.
